stripes_node_seq: RTL and testbench

- Parametrised sequencing node for the bit-serial Stripes tile.
- Accepts a layer-job descriptor and drives the serial NFU-1/2 pipeline's control pins (first_cycle, load, precision, maxpool, enable) across all input bricks, with an input-brick handshake.
- After a fixed pipeline flush, drains Tw output windows one at a time through a window mux to NFU3/bus under valid/ready flow control.
- Replaces hard-wired per-cycle control with an internal FSM.

---
 rtl/stripes_pkg.sv | 31 +++
 rtl/stripes_window_mux.sv | 25 ++
 rtl/stripes_node_seq.sv | 185 ++++++++++++++++++
 tb/tb_stripes_node_seq.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stripes_pkg.sv
// Shared types and helpers for the Stripes sequencing node: FSM encoding,
// default geometry, precision clamp and window slice indexing.
package stripes_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COMPUTE = 3'd1,
    FLUSH   = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam int unsigned DEF_N        = 16;
  localparam int unsigned DEF_TN       = 16;
  localparam int unsigned DEF_TW       = 16;
  localparam int unsigned DEF_PREC_W   = 5;
  localparam int unsigned DEF_BRICK_W  = 8;
  localparam int unsigned DEF_PIPE_LAT = 2;

  // A requested precision of 0, or wider than the lane, runs at full width.
  function automatic int unsigned clamp_precision(input int unsigned prec,
                                                  input int unsigned n);
    return (prec == 0 || prec > n) ? n : prec;
  endfunction

  function automatic int unsigned window_lsb(input int unsigned w,
                                             input int unsigned win_bits);
    return w * win_bits;
  endfunction

endpackage

// File: rtl/stripes_window_mux.sv
// Tw-to-1 selector of N*Tn-bit output windows; with STRIPES_RELU_EN defined,
// negative (signed) N-bit lanes are forced to zero.
module stripes_window_mux
  import stripes_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int Tn = DEF_TN,
  parameter int Tw = DEF_TW,
  localparam int SEL_W = (Tw > 1) ? $clog2(Tw) : 1
) (
  input  logic [N*Tn*Tw-1:0] pipe_result,
  input  logic [SEL_W-1:0]   sel,
  output logic [N*Tn-1:0]    window
);

  always_comb begin
    window = pipe_result[window_lsb(32'(sel), N*Tn) +: N*Tn];
`ifdef STRIPES_RELU_EN
    for (int l = 0; l < Tn; l++) begin
      if (window[l*N + N-1]) window[l*N +: N] = '0;
    end
`endif
  end

endmodule

// File: rtl/stripes_node_seq.sv
// Sequencing node for the bit-serial Stripes tile: runs the NFU-1/2 serial
// pipe over all input bricks, flushes, then drains Tw windows. Optional
// output ReLU via STRIPES_RELU_EN (implemented in stripes_window_mux).
module stripes_node_seq
  import stripes_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int Tn       = DEF_TN,
  parameter int Tw       = DEF_TW,
  parameter int PREC_W   = DEF_PREC_W,
  parameter int BRICK_W  = DEF_BRICK_W,
  parameter int PIPE_LAT = DEF_PIPE_LAT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [PREC_W-1:0]     job_precision,
  input  logic [BRICK_W-1:0]    job_bricks,
  input  logic                  job_maxpool,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  pipe_en,
  output logic                  pipe_first_cycle,
  output logic [Tw-1:0]         pipe_load,
  output logic [PREC_W-1:0]     pipe_precision,
  output logic                  pipe_maxpool,
  input  logic [N*Tn*Tw-1:0]    pipe_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N*Tn-1:0]       out_data,
  output logic                  busy,
  output logic                  done
);

  localparam int WIN_W = N * Tn;
  localparam int SEL_W = (Tw > 1) ? $clog2(Tw) : 1;
  localparam int FL_W  = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  state_t               state, state_next;
  logic [PREC_W-1:0]    prec_q, bit_last_q, c;
  logic [BRICK_W-1:0]   brick_last_q, b;
  logic                 maxpool_q;
  logic [FL_W-1:0]      flush_cnt;
  logic [SEL_W-1:0]     w, mux_sel;
  logic [WIN_W-1:0]     win, out_data_q;
  logic                 out_valid_q;

  logic                 accept, bit_end, brick_end, flush_end, out_fire, win_end;
  logic [PREC_W-1:0]    prec_eff;
  logic [BRICK_W-1:0]   brick_last_eff;

  assign prec_eff       = PREC_W'(clamp_precision(32'(job_precision), N));
  assign brick_last_eff = (job_bricks == '0) ? '0 : job_bricks - 1'b1;

  stripes_window_mux #(.N(N), .Tn(Tn), .Tw(Tw)) u_mux (
    .pipe_result (pipe_result),
    .sel         (mux_sel),
    .window      (win)
  );

  // NOTE: every output and strobe gets a default before the case so no path
  // leaves a signal unassigned; a missing default here would infer a latch.
  always_comb begin
    state_next       = state;
    job_ready        = 1'b0;
    accept           = 1'b0;
    pipe_en          = 1'b0;
    pipe_first_cycle = 1'b0;
    pipe_load        = '0;
    in_ready         = 1'b0;
    done             = 1'b0;
    bit_end          = (c == bit_last_q);
    brick_end        = (b == brick_last_q);
    flush_end        = (flush_cnt == FL_W'(PIPE_LAT - 1));
    out_fire         = out_valid_q && out_ready;
    win_end          = (w == SEL_W'(Tw - 1));
    mux_sel          = (state == DRAIN) ? w + SEL_W'(1) : '0;

    case (state)
      IDLE: begin
        job_ready = 1'b1;
        accept    = job_valid;
        if (accept) state_next = COMPUTE;
      end
      COMPUTE: begin
        // A brick only starts when its input is present; once started it runs to the end.
        pipe_en = in_valid || (c != '0);
        if (pipe_en) begin
          pipe_first_cycle = (c == '0);
          if (c == '0 && b == '0) pipe_load = '1;
          in_ready = bit_end;
          if (bit_end && brick_end) state_next = FLUSH;
        end
      end
      FLUSH: begin
        if (flush_end) state_next = DRAIN;
      end
      DRAIN: begin
        if (out_fire && win_end) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: out_data_q is reset despite its width because it drives a port that
  // must read zero straight out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prec_q       <= '0;
      bit_last_q   <= '0;
      brick_last_q <= '0;
      maxpool_q    <= 1'b0;
      c            <= '0;
      b            <= '0;
      flush_cnt    <= '0;
      w            <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            prec_q       <= prec_eff;
            bit_last_q   <= prec_eff - 1'b1;
            brick_last_q <= brick_last_eff;
            maxpool_q    <= job_maxpool;
            c            <= '0;
            b            <= '0;
          end
        end
        COMPUTE: begin
          if (pipe_en) begin
            if (bit_end) begin
              c <= '0;
              b <= brick_end ? '0 : b + 1'b1;
            end else begin
              c <= c + 1'b1;
            end
          end
        end
        FLUSH: begin
          if (flush_end) begin
            flush_cnt   <= '0;
            w           <= '0;
            out_data_q  <= win;
            out_valid_q <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (out_fire) begin
            if (win_end) begin
              out_valid_q <= 1'b0;
              w           <= '0;
            end else begin
              w          <= w + 1'b1;
              out_data_q <= win;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy           = (state != IDLE);
  assign pipe_precision = busy ? prec_q : '0;
  assign pipe_maxpool   = busy ? maxpool_q : 1'b0;
  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;

endmodule

// File: tb/tb_stripes_node_seq.sv
// Directed, table-driven bench for stripes_node_seq: cycle-exact control
// trace, precision clamp, input stall, drain back-pressure, mid-job reset, ReLU.
module tb_stripes_node_seq;

  localparam int N  = 16;
  localparam int TN = 16;
  localparam int TW = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              job_valid = 1'b0;
  logic              job_ready;
  logic [4:0]        job_precision = '0;
  logic [7:0]        job_bricks = '0;
  logic              job_maxpool = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              pipe_en;
  logic              pipe_first_cycle;
  logic [TW-1:0]     pipe_load;
  logic [4:0]        pipe_precision;
  logic              pipe_maxpool;
  logic [N*TN*TW-1:0] pipe_result = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [N*TN-1:0]   out_data;
  logic              busy;
  logic              done;

  stripes_node_seq dut (
    .clk              (clk),
    .reset            (reset),
    .job_valid        (job_valid),
    .job_ready        (job_ready),
    .job_precision    (job_precision),
    .job_bricks       (job_bricks),
    .job_maxpool      (job_maxpool),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .pipe_en          (pipe_en),
    .pipe_first_cycle (pipe_first_cycle),
    .pipe_load        (pipe_load),
    .pipe_precision   (pipe_precision),
    .pipe_maxpool     (pipe_maxpool),
    .pipe_result      (pipe_result),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit iv;
    bit ordy;
    bit en;
    bit first;
    bit load;
    bit ir;
    bit ov;
    bit dn;
    bit jr;
    int win;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t t1[26];
  vec_t t3[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_win(input string name, input logic [N*TN-1:0] act, input logic [N*TN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N*TN-1:0] repl(input logic [N-1:0] v);
    return {TN{v}};
  endfunction

  function automatic vec_t mk(bit iv, bit ordy, bit en, bit first, bit load, bit ir,
                              bit ov, bit dn, bit jr, int win);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.en = en; v.first = first; v.load = load;
    v.ir = ir; v.ov = ov; v.dn = dn; v.jr = jr; v.win = win;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_windows();
    for (int w = 0; w < TW; w++)
      for (int l = 0; l < TN; l++)
        pipe_result[(w*TN + l)*N +: N] = N'(w + 1);
  endtask

  task automatic start_job(input logic [4:0] prec, input logic [7:0] bricks, input logic mp);
    int i = 0;
    while (!job_ready && i < 200) begin
      tick();
      i++;
    end
    check("job_ready_wait", 32'(job_ready), 32'd1);
    job_precision = prec;
    job_bricks    = bricks;
    job_maxpool   = mp;
    job_valid     = 1'b1;
    tick();
    job_valid     = 1'b0;
    job_precision = '0;
    job_bricks    = '0;
    job_maxpool   = 1'b0;
  endtask

  task automatic apply_row(input string tag, input vec_t v);
    in_valid  = v.iv;
    out_ready = v.ordy;
    #1;
    check({tag, "_en"},    32'(pipe_en),          32'(v.en));
    check({tag, "_first"}, 32'(pipe_first_cycle), 32'(v.first));
    check({tag, "_load"},  32'(pipe_load),        32'({TW{v.load}}));
    check({tag, "_inrdy"}, 32'(in_ready),         32'(v.ir));
    check({tag, "_oval"},  32'(out_valid),        32'(v.ov));
    check({tag, "_done"},  32'(done),             32'(v.dn));
    check({tag, "_jrdy"},  32'(job_ready),        32'(v.jr));
    check({tag, "_busy"},  32'(busy),             32'(!v.jr));
    if (v.win >= 0) check_win({tag, "_data"}, out_data, repl(N'(v.win)));
    tick();
  endtask

  task automatic run_to_done(input int budget, output int en_cnt);
    bit seen = 1'b0;
    en_cnt = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (pipe_en) en_cnt++;
      if (done) seen = 1'b1;
      tick();
    end
    check("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic run_prec(input logic [4:0] prec);
    int n;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    start_job(prec, 8'd1, 1'b1);
    check("clamp_prec",    32'(pipe_precision), 32'd16);
    check("clamp_maxpool", 32'(pipe_maxpool),   32'd1);
    run_to_done(400, n);
    check("clamp_en_cycles", 32'(n), 32'd16);
    check("idle_prec",    32'(pipe_precision), 32'd0);
    check("idle_maxpool", 32'(pipe_maxpool),   32'd0);
  endtask

  initial begin
    bit pat[4];
    int n, j, hs;
    bit fin;

    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    // Test 1 table: p=3, B=2, no stalls.
    t1[0] = mk(1,1, 1,1,1,0, 0,0,0, -1);
    t1[1] = mk(1,1, 1,0,0,0, 0,0,0, -1);
    t1[2] = mk(1,1, 1,0,0,1, 0,0,0, -1);
    t1[3] = mk(1,1, 1,1,0,0, 0,0,0, -1);
    t1[4] = mk(1,1, 1,0,0,0, 0,0,0, -1);
    t1[5] = mk(1,1, 1,0,0,1, 0,0,0, -1);
    t1[6] = mk(1,1, 0,0,0,0, 0,0,0, -1);
    t1[7] = mk(1,1, 0,0,0,0, 0,0,0, -1);
    for (int k = 9; k <= 24; k++) t1[k-1] = mk(1,1, 0,0,0,0, 1,0,0, k-8);
    t1[24] = mk(1,1, 0,0,0,0, 0,1,0, -1);
    t1[25] = mk(1,1, 0,0,0,0, 0,0,1, -1);

    // Test 3 table: p=2, B=2, in_valid low for the first 4 cycles of brick 1.
    t3[0] = mk(1,1, 1,1,1,0, 0,0,0, -1);
    t3[1] = mk(1,1, 1,0,0,1, 0,0,0, -1);
    for (int k = 3; k <= 6; k++) t3[k-1] = mk(0,1, 0,0,0,0, 0,0,0, -1);
    t3[6] = mk(1,1, 1,1,0,0, 0,0,0, -1);
    t3[7] = mk(1,1, 1,0,0,1, 0,0,0, -1);
    t3[8] = mk(1,1, 0,0,0,0, 0,0,0, -1);

    set_windows();

    // Reset state.
    #3;
    check("rst_jrdy",  32'(job_ready),      32'd1);
    check("rst_busy",  32'(busy),           32'd0);
    check("rst_en",    32'(pipe_en),        32'd0);
    check("rst_oval",  32'(out_valid),      32'd0);
    check("rst_done",  32'(done),           32'd0);
    check("rst_prec",  32'(pipe_precision), 32'd0);
    check_win("rst_data", out_data, '0);
    #9 reset = 1'b1;
    tick();

    // Test 1.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    start_job(5'd3, 8'd2, 1'b0);
    check("t1_prec",    32'(pipe_precision), 32'd3);
    check("t1_maxpool", 32'(pipe_maxpool),   32'd0);
    for (int k = 0; k < 26; k++) apply_row($sformatf("t1_c%0d", k + 1), t1[k]);

    // Test 2: precision clamp.
    run_prec(5'd0);
    run_prec(5'd20);

    // Test 3: input stall at the start of brick 1.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    start_job(5'd2, 8'd2, 1'b0);
    for (int k = 0; k < 9; k++) apply_row($sformatf("t3_c%0d", k + 1), t3[k]);
    in_valid = 1'b1;
    run_to_done(100, n);

    // Test 4: drain back-pressure with out_ready 1,0,0,1.
    in_valid  = 1'b1;
    out_ready = 1'b0;
    start_job(5'd1, 8'd1, 1'b0);
    j = 0;
    hs = 0;
    fin = 1'b0;
    for (int i = 0; i < 200 && !fin; i++) begin
      if (done) begin
        fin = 1'b1;
      end else if (out_valid) begin
        out_ready = pat[j % 4];
        j++;
        #1;
        if (out_ready) begin
          check_win($sformatf("drain_hs%0d", hs), out_data, repl(N'(hs + 1)));
          hs++;
        end else begin
          check_win($sformatf("drain_stall%0d", hs), out_data, repl(N'(hs + 1)));
        end
      end
      tick();
    end
    check("drain_done_seen", 32'(fin), 32'd1);
    check("drain_hs_count",  32'(hs),  32'd16);
    out_ready = 1'b1;

    // Test 5: reset mid-COMPUTE, then a fresh job.
    start_job(5'd3, 8'd4, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    check("t5_busy_pre", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("t5_jrdy", 32'(job_ready),      32'd1);
    check("t5_busy", 32'(busy),           32'd0);
    check("t5_en",   32'(pipe_en),        32'd0);
    check("t5_inrdy",32'(in_ready),       32'd0);
    check("t5_prec", 32'(pipe_precision), 32'd0);
    check("t5_mp",   32'(pipe_maxpool),   32'd0);
    check("t5_oval", 32'(out_valid),      32'd0);
    check("t5_done", 32'(done),           32'd0);
    #2 reset = 1'b1;
    start_job(5'd2, 8'd1, 1'b0);
    check("t5_new_busy", 32'(busy),           32'd1);
    check("t5_new_prec", 32'(pipe_precision), 32'd2);
    run_to_done(100, n);
    check("t5_new_en_cycles", 32'(n), 32'd2);

    // Test 6: ReLU lanes.
    pipe_result[0 +: N]  = 16'h8001;
    pipe_result[N +: N]  = 16'h7FFF;
    out_ready = 1'b0;
    start_job(5'd1, 8'd1, 1'b0);
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    check("relu_valid", 32'(out_valid), 32'd1);
`ifdef STRIPES_RELU_EN
    check("relu_lane0", 32'(out_data[0 +: N]), 32'h0000);
`else
    check("relu_lane0", 32'(out_data[0 +: N]), 32'h8001);
`endif
    check("relu_lane1", 32'(out_data[N +: N]),   32'h7FFF);
    check("relu_lane2", 32'(out_data[2*N +: N]), 32'h0001);
    out_ready = 1'b1;
    run_to_done(100, n);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
